mem_stage: RTL

Data-memory access stage of the RV32I pipeline. Sits between the EX/MEM boundary and write-back. Consumes the `rv32i_control_word` and the ALU result. Performs byte-lane alignment, runs a request/response handshake with the data cache, and sign- or zero-extends load data. Owns the MEM/WB pipeline register, and raises a stall while a memory access is outstanding.

---
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// RV32I data-memory stage: byte-lane alignment, data-cache handshake, load extension
// and the MEM/WB pipeline register. Stalls the front of the pipe while an access is open.
package rv32i_types;
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] aluop;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_enable;
    } rv32i_control_word;
endpackage

module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  rv32i_control_word ex_ctrl,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rs2_data,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_pc,
    output logic              mem_stall,
    output logic              data_read,
    output logic              data_write,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              wb_valid,
    output rv32i_control_word wb_ctrl,
    output logic [31:0]       wb_alu_out,
    output logic [31:0]       wb_load_data,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_pc,
    output logic              wb_trap,
    output logic [31:0]       wb_mem_addr,
    output logic [3:0]        wb_mem_rmask,
    output logic [3:0]        wb_mem_wmask,
    output logic [31:0]       wb_mem_wdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic              req_read, req_write;
    logic [31:0]       req_addr, req_wdata, req_alu_out, req_pc;
    logic [3:0]        req_mbe;
    logic [2:0]        req_funct3;
    logic [1:0]        req_off;
    logic [4:0]        req_rd;
    rv32i_control_word req_ctrl;

    logic              is_load, is_store, mem_op, legal, issue, trap;
    logic [1:0]        off;
    logic [3:0]        mbe;
    logic [31:0]       wdata, shifted, load_ext;
    rv32i_control_word ctrl_mbe;

    // Decode legality, byte enables and lane-replicated store data for the EX/MEM slot.
    always_comb begin
        off      = ex_alu_out[1:0];
        is_load  = ex_ctrl.mem_read;
        is_store = ex_ctrl.mem_write & ~ex_ctrl.mem_read;
        mem_op   = ex_valid & (is_load | is_store);
        legal    = 1'b0;
        case (ex_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~off[0];
            3'b010:  legal = (off == 2'b00);
            3'b100:  legal = is_load;
            3'b101:  legal = is_load & ~off[0];
            default: legal = 1'b0;
        endcase
        case (ex_funct3[1:0])
            2'b00:   mbe = 4'b0001 << off;
            2'b01:   mbe = 4'b0011 << off;
            default: mbe = 4'b1111 << off;
        endcase
        case (ex_funct3[1:0])
            2'b00:   wdata = {4{ex_rs2_data[7:0]}};
            2'b01:   wdata = {2{ex_rs2_data[15:0]}};
            default: wdata = ex_rs2_data;
        endcase
        issue    = mem_op & legal;
        trap     = mem_op & ~legal;
        ctrl_mbe = ex_ctrl;
        ctrl_mbe.mem_byte_enable = mbe;
    end

    always_comb begin
        shifted = data_rdata >> {req_off, 3'b000};
        case (req_funct3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = data_rdata;
        endcase
    end

    assign data_read  = (state == BUSY) & req_read;
    assign data_write = (state == BUSY) & req_write;
    assign data_addr  = req_addr;
    assign data_mbe   = req_mbe;
    assign data_wdata = req_wdata;
    assign mem_stall  = ~rst & (((state == IDLE) & issue) | ((state == BUSY) & ~data_resp));

    // MEM/WB defaults to a bubble each cycle; the branches below overwrite it when something retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_read     <= 1'b0;
            req_write    <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_alu_out  <= '0;
            req_pc       <= '0;
            req_mbe      <= '0;
            req_funct3   <= '0;
            req_off      <= '0;
            req_rd       <= '0;
            req_ctrl     <= '0;
            wb_valid     <= 1'b0;
            wb_ctrl      <= '0;
            wb_alu_out   <= '0;
            wb_load_data <= '0;
            wb_rd        <= '0;
            wb_pc        <= '0;
            wb_trap      <= 1'b0;
            wb_mem_addr  <= '0;
            wb_mem_rmask <= '0;
            wb_mem_wmask <= '0;
            wb_mem_wdata <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_ctrl      <= '0;
            wb_alu_out   <= '0;
            wb_load_data <= '0;
            wb_rd        <= '0;
            wb_pc        <= '0;
            wb_trap      <= 1'b0;
            wb_mem_addr  <= '0;
            wb_mem_rmask <= '0;
            wb_mem_wmask <= '0;
            wb_mem_wdata <= '0;
            if (state == IDLE) begin
                if (issue) begin
                    state       <= BUSY;
                    req_read    <= is_load;
                    req_write   <= is_store;
                    req_addr    <= {ex_alu_out[31:2], 2'b00};
                    req_mbe     <= mbe;
                    req_wdata   <= wdata;
                    req_funct3  <= ex_funct3;
                    req_off     <= off;
                    req_ctrl    <= ctrl_mbe;
                    req_alu_out <= ex_alu_out;
                    req_rd      <= ex_rd;
                    req_pc      <= ex_pc;
                end else begin
                    wb_valid   <= ex_valid;
                    wb_ctrl    <= ex_ctrl;
                    wb_ctrl.mem_byte_enable <= '0;
                    wb_alu_out <= ex_alu_out;
                    wb_rd      <= ex_rd;
                    wb_pc      <= ex_pc;
                    wb_trap    <= trap;
                    if (trap)
                        wb_mem_addr <= {ex_alu_out[31:2], 2'b00};
                end
            end else if (data_resp) begin
                state        <= IDLE;
                wb_valid     <= 1'b1;
                wb_ctrl      <= req_ctrl;
                wb_alu_out   <= req_alu_out;
                wb_load_data <= req_read ? load_ext : 32'd0;
                wb_rd        <= req_rd;
                wb_pc        <= req_pc;
                wb_mem_addr  <= req_addr;
                wb_mem_rmask <= req_read ? req_mbe : 4'b0000;
                wb_mem_wmask <= req_write ? req_mbe : 4'b0000;
                wb_mem_wdata <= req_write ? req_wdata : 32'd0;
            end
        end
    end

endmodule
